// File: rtl/touch_adc_reader_if.sv
// Pin bundle between the touch ADC reader and the ADS7843-style controller,
// plus the published touch coordinates/phase.
interface touch_adc_reader_if;
  logic       penirq_n;
  logic       dout;
  logic       cs_n;
  logic       dclk;
  logic       din;
  logic [9:0] tor_x;
  logic [8:0] tor_y;
  logic [1:0] clcount;
  logic       enable;

  modport master (input penirq_n, dout,
                  output cs_n, dclk, din, tor_x, tor_y, clcount, enable);
  modport slave  (output penirq_n, dout,
                  input cs_n, dclk, din, tor_x, tor_y, clcount, enable);
endinterface

// File: rtl/touch_adc_reader.sv
// ADS7843 SPI mode-0 reader: pen-down detect, X/Y 12-bit conversions,
// scaling to 800x480 and touch-phase strobes.
module touch_adc_reader #(
  parameter int          CLK_DIV    = 25,
  parameter int          GAP_CYCLES = 500000,
  parameter logic [7:0]  CMD_X      = 8'hD0,
  parameter logic [7:0]  CMD_Y      = 8'h90
) (
  input  logic clk,
  input  logic reset,
  touch_adc_reader_if.master bus
);
  localparam int DW = $clog2(CLK_DIV);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_XFER_X, S_XFER_Y, S_CHECK, S_PUBLISH, S_GAP
  } state_t;

  state_t        r_state, w_next;
  logic [DW-1:0] r_div;
  logic [5:0]    r_half;
  logic [GW-1:0] r_gap;
  logic          r_pen_s1, r_pen_s2;
  logic [15:0]   r_shift;
  logic [11:0]   r_raw_x;
  logic          r_pressed, r_dclk, r_din, r_cs_n;
  logic [9:0]    r_tor_x;
  logic [8:0]    r_tor_y;
  logic [1:0]    r_clcount;

  logic          w_xfer, w_tick, w_frame_end, w_gap_end, w_pen;
  logic [4:0]    w_next_per;
  logic [7:0]    w_cmd;
  logic [9:0]    w_tor_x;
  logic [8:0]    w_tor_y;

  assign w_xfer      = (r_state == S_XFER_X) || (r_state == S_XFER_Y);
  assign w_tick      = (r_div == DW'(CLK_DIV - 1));
  assign w_frame_end = w_tick && (r_half == 6'd47);
  assign w_gap_end   = (r_gap == GW'(GAP_CYCLES - 1));
  assign w_pen       = !r_pen_s2;
  // Falling edges always leave an odd half index, so the next period is half/2+1.
  assign w_next_per  = r_half[5:1] + 5'd1;
  assign w_cmd       = (r_state == S_XFER_X) ? CMD_X : CMD_Y;
  assign w_tor_x     = 10'((22'(r_raw_x) * 22'd800) >> 12);
  assign w_tor_y     = 9'((21'(r_shift[14:3]) * 21'd480) >> 12);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_pen) w_next = S_XFER_X;
      S_XFER_X:  if (w_frame_end) w_next = S_XFER_Y;
      S_XFER_Y:  if (w_frame_end) w_next = S_CHECK;
      S_CHECK:   w_next = (w_pen || r_pressed) ? S_PUBLISH : S_IDLE;
      S_PUBLISH: w_next = (r_clcount == 2'd3) ? S_IDLE : S_GAP;
      S_GAP:     if (w_gap_end) w_next = S_XFER_X;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.enable = (r_state == S_PUBLISH);
  end

  assign bus.cs_n    = r_cs_n;
  assign bus.dclk    = r_dclk;
  assign bus.din     = r_din;
  assign bus.tor_x   = r_tor_x;
  assign bus.tor_y   = r_tor_y;
  assign bus.clcount = r_clcount;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pen_s1  <= 1'b1;
      r_pen_s2  <= 1'b1;
      r_cs_n    <= 1'b1;
      r_dclk    <= 1'b0;
      r_din     <= 1'b0;
      r_div     <= '0;
      r_half    <= '0;
      r_gap     <= '0;
      r_shift   <= '0;
      r_raw_x   <= '0;
      r_pressed <= 1'b0;
      r_tor_x   <= '0;
      r_tor_y   <= '0;
      r_clcount <= '0;
    end else begin
      r_pen_s1 <= bus.penirq_n;
      r_pen_s2 <= r_pen_s1;
      r_cs_n   <= !((w_next == S_XFER_X) || (w_next == S_XFER_Y));
      r_gap    <= (r_state == S_GAP) ? r_gap + GW'(1) : '0;

      if (w_xfer) begin
        if (w_tick) begin
          r_div  <= '0;
          r_dclk <= !r_dclk;
          r_half <= w_frame_end ? 6'd0 : r_half + 6'd1;
          if (!r_dclk) begin
            r_shift <= {r_shift[14:0], bus.dout};
          end else if (w_frame_end) begin
            r_din <= (r_state == S_XFER_X) ? CMD_Y[7] : 1'b0;
            if (r_state == S_XFER_X) r_raw_x <= r_shift[14:3];
          end else begin
            r_din <= (w_next_per < 5'd8) ? w_cmd[3'd7 - w_next_per[2:0]] : 1'b0;
          end
        end else begin
          r_div <= r_div + DW'(1);
        end
      end else begin
        r_div  <= '0;
        r_half <= '0;
        r_dclk <= 1'b0;
        // Present the first command bit together with the cs_n fall.
        r_din  <= (w_next == S_XFER_X) ? CMD_X[7] : 1'b0;
      end

      if (r_state == S_CHECK && (w_pen || r_pressed)) begin
        r_clcount <= w_pen ? (r_pressed ? 2'd2 : 2'd1) : 2'd3;
        if (w_pen) begin
          r_tor_x <= w_tor_x;
          r_tor_y <= w_tor_y;
        end
      end

      if (r_state == S_PUBLISH) r_pressed <= (r_clcount != 2'd3);
    end
  end
endmodule

// File: tb/tb_touch_adc_reader.sv
// Randomised bench with an ADS7843 pin model and a sample-level scoreboard.
module tb_touch_adc_reader;
  localparam int CD  = 2;
  localparam int GAP = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  touch_adc_reader_if bus();

  touch_adc_reader #(.CLK_DIV(CD), .GAP_CYCLES(GAP), .CMD_X(8'hD0), .CMD_Y(8'h90)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Controller model: latches the command byte, returns {0, raw, 000} MSB first.
  int         mx, my;
  int         bitcnt = 0;
  logic [7:0] cmd;
  logic [7:0] q_cmd[$];

  initial bus.dout = 1'b0;

  always @(negedge bus.cs_n or posedge bus.dclk) begin
    if (!bus.dclk) begin
      bitcnt = 0;
      q_cmd.delete();
    end else begin
      bitcnt++;
      if (bitcnt <= 8) cmd = {cmd[6:0], bus.din};
      if (bitcnt == 8) q_cmd.push_back(cmd);
      if (bitcnt == 24) bitcnt = 0;
    end
  end

  always @(negedge bus.dclk) begin
    logic [15:0] word;
    word = (cmd == 8'hD0) ? {1'b0, mx[11:0], 3'b000} : {1'b0, my[11:0], 3'b000};
    if (bitcnt >= 8 && bitcnt < 24) bus.dout = word[15 - (bitcnt - 8)];
    else bus.dout = 1'b0;
  end

  // Scoreboard: each completed sample predicts at most one strobe.
  typedef struct { int cl; int x; int y; } exp_t;
  exp_t q_exp[$];
  bit   m_pressed;
  int   m_x, m_y;
  int   since_rise = 100, low_run = 0, n_strobe = 0, n_rise = 0;
  int   last_cl, last_x, last_y;
  bit   prev_cs = 1'b1, prev_en = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      q_exp.delete();
      m_pressed = 0; m_x = 0; m_y = 0;
      low_run = 0; since_rise = 100;
    end else begin
      if (!bus.cs_n) low_run++;
      if (!prev_cs && bus.cs_n) begin
        n_rise++;
        chk("cs_len", low_run, 96 * CD);
        if (q_cmd.size() == 2) begin
          chk("cmd_x", int'(q_cmd[0]), 8'hD0);
          chk("cmd_y", int'(q_cmd[1]), 8'h90);
        end else chk("cmd_cnt", q_cmd.size(), 2);
        low_run = 0;
        since_rise = 1;
        if (!bus.penirq_n) begin
          m_x = (mx * 800) / 4096;
          m_y = (my * 480) / 4096;
          e.cl = m_pressed ? 2 : 1; e.x = m_x; e.y = m_y;
          m_pressed = 1;
          q_exp.push_back(e);
        end else if (m_pressed) begin
          e.cl = 3; e.x = m_x; e.y = m_y;
          m_pressed = 0;
          q_exp.push_back(e);
        end
      end else since_rise++;
      if (bus.enable) begin
        n_strobe++;
        chk("en_lat", since_rise, 2);
        chk("en_dbl", int'(prev_en), 0);
        if (q_exp.size() == 0) chk("unexp_en", 1, 0);
        else begin
          e = q_exp.pop_front();
          chk("clcount", int'(bus.clcount), e.cl);
          chk("tor_x", int'(bus.tor_x), e.x);
          chk("tor_y", int'(bus.tor_y), e.y);
        end
        last_cl = bus.clcount; last_x = bus.tor_x; last_y = bus.tor_y;
      end
    end
    prev_cs = bus.cs_n;
    prev_en = bus.enable;
  end

  task automatic wait_strobe(input int target);
    int t = 0;
    while (n_strobe < target && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("strobe_timeout", int'(n_strobe >= target), 1);
  endtask

  task automatic idle_check(input string tag, input int cycles);
    int nact = 0;
    int base = n_strobe;
    repeat (cycles) begin
      @(negedge clk);
      if (!bus.cs_n) nact++;
    end
    chk(tag, nact, 0);
    chk({tag, "_en"}, n_strobe - base, 0);
  endtask

  initial begin
    int n, base, holds, r0;
    mx = 12'h800; my = 12'h400;
    bus.penirq_n = 1'b0;
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_outs", int'({bus.cs_n, bus.dclk, bus.enable, bus.tor_x, bus.tor_y, bus.clcount}),
          24'h800000);
    end
    reset = 1'b0;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (!bus.cs_n) break;
    end
    chk("pd_latency", n, 3);

    // Press, hold one more sample, release during the gap.
    wait_strobe(1);
    chk("press_cl", last_cl, 1);
    chk("press_x", last_x, 400);
    chk("press_y", last_y, 120);
    wait_strobe(2);
    chk("hold_cl", last_cl, 2);
    repeat (3) @(negedge clk);
    bus.penirq_n = 1'b1;
    wait_strobe(3);
    chk("rel_cl", last_cl, 3);
    chk("rel_x", last_x, 400);
    chk("rel_y", last_y, 120);
    idle_check("idle_after_rel", 400);

    // Random press/hold/release rounds; first two hit full scale and zero.
    for (int it = 0; it < 6; it++) begin
      mx = (it == 0) ? 4095 : (it == 1) ? 0 : $urandom_range(0, 4095);
      my = (it == 0) ? 4095 : (it == 1) ? 0 : $urandom_range(0, 4095);
      base = n_strobe;
      bus.penirq_n = 1'b0;
      wait_strobe(base + 1);
      if (it == 0) begin
        chk("fs_x", last_x, 799);
        chk("fs_y", last_y, 479);
      end else if (it == 1) begin
        chk("zero_x", last_x, 0);
        chk("zero_y", last_y, 0);
      end
      holds = $urandom_range(0, 2);
      for (int h = 0; h < holds; h++) begin
        mx = $urandom_range(0, 4095);
        my = $urandom_range(0, 4095);
        wait_strobe(base + 2 + h);
      end
      mx = $urandom_range(0, 4095);
      bus.penirq_n = 1'b1;
      wait_strobe(base + 2 + holds);
      repeat ($urandom_range(5, 40)) @(negedge clk);
    end
    chk("exp_left", q_exp.size(), 0);

    // Short glitch: one transfer, no strobe.
    r0 = n_rise;
    base = n_strobe;
    bus.penirq_n = 1'b0;
    repeat (10) @(negedge clk);
    bus.penirq_n = 1'b1;
    repeat (400) @(negedge clk);
    chk("glitch_xfer", n_rise - r0, 1);
    chk("glitch_en", n_strobe - base, 0);

    // Reset during bit 12 of the X frame.
    bus.penirq_n = 1'b0;
    n = 0;
    while (bus.cs_n && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("mid_cs_fall", int'(bus.cs_n), 0);
    repeat (45) @(negedge clk);
    reset = 1'b1;
    bus.penirq_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_cs", int'(bus.cs_n), 1);
    chk("mid_rst_dclk", int'(bus.dclk), 0);
    @(negedge clk);
    reset = 1'b0;
    idle_check("mid_rst_idle", 400);
    chk("exp_left_end", q_exp.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
